// File: rtl/cnn_sdiv_21s_7ns_14s.sv
// Sequential signed divider: 21-bit signed dividend by 7-bit unsigned divisor, one restoring
// quotient bit per cycle. Define CNN_SDIV_SAT_EN to saturate out-of-range quotients.
module cnn_sdiv_21s_7ns_14s #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 21,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [7:0]            rem,
  output logic                  ovf
);

  if (din0_WIDTH != 21 || din1_WIDTH != 7 || dout_WIDTH != 14 || ID < 0) begin : g_bad_cfg
    $error("cnn_sdiv_21s_7ns_14s: unsupported configuration");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [20:0] mag_q;   // dividend magnitude, shifted out MSB first; quotient shifts in
  logic [6:0]  r_q;
  logic [6:0]  d_q;
  logic        neg_q;

  logic [7:0]  r_shift;
  logic        qbit;
  logic [6:0]  r_next;
  logic [20:0] q_next;
  logic [13:0] q_low;
  logic        q_big;
  logic [13:0] lim;
  logic [13:0] dout_res;
  logic [7:0]  rem_res;
  logic        ovf_res;

  always_comb begin
    r_shift = {r_q, mag_q[20]};
    qbit    = r_shift >= {1'b0, d_q};
    // The true difference is below 128 whenever it is taken, so 7-bit arithmetic suffices.
    r_next  = qbit ? (r_shift[6:0] - d_q) : r_shift[6:0];
    q_next  = {mag_q[19:0], qbit};
    q_low   = neg_q ? (14'd0 - q_next[13:0]) : q_next[13:0];
    q_big   = neg_q ? (q_next > 21'd8192) : (q_next > 21'd8191);
    lim     = neg_q ? 14'h2000 : 14'h1fff;
    if (d_q == 7'd0) begin
      dout_res = lim;
      rem_res  = 8'd0;
      ovf_res  = 1'b1;
    end else begin
      rem_res  = neg_q ? (8'd0 - {1'b0, r_next}) : {1'b0, r_next};
      ovf_res  = q_big;
`ifdef CNN_SDIV_SAT_EN
      dout_res = q_big ? lim : q_low;
`else
      dout_res = q_low;
`endif
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      mag_q   <= 21'd0;
      r_q     <= 7'd0;
      d_q     <= 7'd0;
      neg_q   <= 1'b0;
      dout    <= '0;
      rem     <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            neg_q   <= din0[20];
            mag_q   <= din0[20] ? (21'd0 - din0) : din0;
            d_q     <= din1;
            r_q     <= 7'd0;
            cnt_q   <= 5'd0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          mag_q <= q_next;
          r_q   <= r_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd20) begin
            dout    <= dout_res;
            rem     <= rem_res;
            ovf     <= ovf_res;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ap_idle  = (state_q == StIdle);
  assign ap_done  = (state_q == StDone);
  assign ap_ready = (state_q == StDone);

endmodule

// File: doc/cnn_sdiv_21s_7ns_14s.md
CNN_SDIV_21S_7NS_14S -- requirements
Module: cnn_sdiv_21s_7ns_14s

Interface
REQ-001 The block SHALL declare parameter ID, default 1, instance identifier with no functional effect.
REQ-002 The block SHALL declare parameter din0_WIDTH, default 21, dividend width; only 21 is supported.
REQ-003 The block SHALL declare parameter din1_WIDTH, default 7, divisor width; only 7 is supported.
REQ-004 The block SHALL declare parameter dout_WIDTH, default 14, quotient width; only 14 is supported.
REQ-005 The block SHALL have port ap_clk, input, 1 bit, single clock, all state updates on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port ap_start, input, 1 bit, request to begin a division.
REQ-008 The block SHALL have port din0, input, 21 bits, signed two's-complement dividend.
REQ-009 The block SHALL have port din1, input, 7 bits, unsigned divisor.
REQ-010 The block SHALL have port ap_done, output, 1 bit, one-cycle completion pulse.
REQ-011 The block SHALL have port ap_idle, output, 1 bit, high while in IDLE.
REQ-012 The block SHALL have port ap_ready, output, 1 bit, one-cycle pulse coincident with ap_done.
REQ-013 The block SHALL have port dout, output, 14 bits, signed quotient.
REQ-014 The block SHALL have port rem, output, 8 bits, signed remainder.
REQ-015 The block SHALL have port ovf, output, 1 bit, set when the quotient does not fit 14 bits or din1 is 0.

Function
REQ-016 The FSM SHALL use states IDLE, CALC and DONE: IDLE->CALC on ap_start=1; CALC->DONE after 21 CALC cycles; DONE->IDLE unconditionally.
REQ-017 On the IDLE edge accepting ap_start, the block SHALL latch din0, din1, sign(din0) and |din0| as a 21-bit unsigned value; -1048576 SHALL give magnitude 1048576.
REQ-018 CALC SHALL perform one restoring shift-subtract quotient bit per cycle, MSB first, for 21 cycles, and SHALL use no multiplier or divider operator.
REQ-019 Division SHALL truncate toward zero; quotient sign = sign(din0); remainder sign = sign(din0); |rem| < din1.
REQ-020 ap_done and ap_ready SHALL be high only during the single DONE cycle, which is the 22nd cycle after the accepting edge.
REQ-021 dout, rem and ovf SHALL update on entry to DONE and hold until the next DONE or reset.
REQ-022 ap_start SHALL be ignored in CALC and DONE; ap_start held high SHALL give one transaction every 23 cycles.
REQ-023 Inputs SHALL be sampled only on the accepting edge; later changes to din0 or din1 SHALL not affect the result.
REQ-024 When din1=0, the block SHALL output ovf=1, rem=0, and dout=8191 if din0>=0 or dout=-8192 if din0<0, regardless of configuration.
REQ-025 When the 21-bit signed quotient lies outside [-8192, 8191], ovf SHALL be 1; otherwise ovf SHALL be 0.

Reset
REQ-026 On ap_rst_n=0, the block SHALL immediately enter IDLE with ap_idle=1 and ap_done=0, ap_ready=0, dout=0, rem=0, ovf=0, and all internal registers cleared.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no ap_done pulse.
REQ-028 The first ap_start SHALL be accepted on the first rising edge after ap_rst_n deasserts.

Configuration
REQ-029 With macro CNN_SDIV_SAT_EN defined, out-of-range quotients SHALL saturate dout to 8191 or -8192.
REQ-030 Without CNN_SDIV_SAT_EN, out-of-range quotients SHALL output the low 14 bits of the two's-complement quotient, ovf still asserted, and divide-by-zero still follows REQ-024.

Verification
REQ-031 din0=1000, din1=7 -> dout=142, rem=6, ovf=0, ap_done high exactly 22 cycles after the accepting edge.
REQ-032 din0=-1000, din1=7 -> dout=-142, rem=-6, ovf=0.
REQ-033 din0=1048575, din1=1 -> with macro dout=8191, ovf=1; without macro dout=-1 (0x3FFF), ovf=1.
REQ-034 din0=-5, din1=0 -> dout=-8192, rem=0, ovf=1; din0=5, din1=0 -> dout=8191.
REQ-035 ap_rst_n pulsed low at CALC cycle 10 -> ap_idle=1, dout=0, no ap_done; then din0=21, din1=3 -> dout=7, rem=0.
REQ-036 ap_start held high with din0 changed every cycle -> ap_done period 23 cycles, each result matching the din0 value at its accepting edge.
